comparator_sort_controller: RTL

Sequential controller that loads up to DEPTH unsigned words, then sorts them in ascending order with bubble-sort passes that share one internal magnitude comparator. Each pair comparison takes one cycle; each swap takes one extra cycle. The block sits between a producer that streams operands in and a consumer that reads the sorted result by address. It is the sequencing layer above the team's 4-bit magnitude comparator datapath.

---
 rtl/comparator_sort_controller.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/comparator_sort_controller.sv
// Load-then-sort controller: bubble-sorts up to DEPTH unsigned words in place using one
// shared magnitude comparator, then exposes the ascending result through a read port.
module comparator_sort_controller #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic                     load_valid_i,
  input  logic [WIDTH-1:0]         load_data_i,
  output logic                     load_ready_o,
  input  logic                     start_i,
  input  logic                     clear_i,
  output logic                     busy_o,
  output logic                     done_o,
  input  logic [$clog2(DEPTH)-1:0] rd_addr_i,
  output logic [WIDTH-1:0]         rd_data_o,
  output logic [7:0]               swap_count_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] DepthC = CW'(DEPTH);

  typedef enum logic [2:0] {
    StIdle,
    StCompare,
    StSwap,
    StPassEnd,
    StDone
  } state_e;

  state_e           state_q;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [CW-1:0]    count_q;
  logic [CW-1:0]    n_q;
  logic [AW-1:0]    idx_q;
  logic             swapped_q;
  logic [7:0]       swap_count_q;
  logic             busy_q;
  logic             done_q;

  logic [AW-1:0]    idx_nx;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             a_gt_b;
  logic             last_pair;
  logic             can_load;

  // Shared comparator: always looks at the current adjacent pair.
  always_comb begin
    idx_nx    = idx_q + AW'(1);
    op_a      = mem_q[idx_q];
    op_b      = mem_q[idx_nx];
    a_gt_b    = op_a > op_b;
    last_pair = (CW'(idx_q) == (n_q - CW'(2)));
    can_load  = (state_q == StIdle) && (count_q < DepthC);
  end

  // start wins over a same-cycle load, so ready drops while start is high.
  assign load_ready_o = can_load && !start_i;
  assign busy_o       = busy_q;
  assign done_o       = done_q;
  assign swap_count_o = swap_count_q;
  assign rd_data_o    = (32'(rd_addr_i) < DEPTH) ? mem_q[rd_addr_i] : '0;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q      <= StIdle;
      count_q      <= '0;
      n_q          <= '0;
      idx_q        <= '0;
      swapped_q    <= 1'b0;
      swap_count_q <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start_i) begin
            idx_q        <= '0;
            swapped_q    <= 1'b0;
            swap_count_q <= '0;
            if (count_q < CW'(2)) begin
              state_q <= StDone;
              done_q  <= 1'b1;
            end else begin
              n_q     <= count_q;
              state_q <= StCompare;
              busy_q  <= 1'b1;
            end
          end else if (load_valid_i && can_load) begin
            mem_q[count_q[AW-1:0]] <= load_data_i;
            count_q                <= count_q + CW'(1);
          end
        end

        StCompare: begin
          if (a_gt_b) begin
            state_q <= StSwap;
          end else if (last_pair) begin
            state_q <= StPassEnd;
          end else begin
            idx_q <= idx_nx;
          end
        end

        StSwap: begin
          mem_q[idx_q]  <= op_b;
          mem_q[idx_nx] <= op_a;
          swapped_q     <= 1'b1;
          swap_count_q  <= swap_count_q + 8'd1;
          if (last_pair) begin
            state_q <= StPassEnd;
          end else begin
            idx_q   <= idx_nx;
            state_q <= StCompare;
          end
        end

        StPassEnd: begin
          if (swapped_q) begin
            idx_q     <= '0;
            swapped_q <= 1'b0;
            state_q   <= StCompare;
          end else begin
            state_q <= StDone;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end

        StDone: begin
          if (clear_i) begin
            count_q <= '0;
            done_q  <= 1'b0;
            state_q <= StIdle;
          end
        end

        default: begin
          state_q <= StIdle;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

endmodule
